// File: rtl/switch_pkt_feeder.sv
// Store-and-forward packet buffer feeding the switch input port.
// Only complete packets are released; oversize packets roll back.
module switch_pkt_feeder #(
   parameter int WORD_WIDTH = 8,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [WORD_WIDTH-1:0]         in_data,
   output logic                          in_ready,
   output logic                          sw_enable_in,
   output logic [WORD_WIDTH-1:0]         data_in,
   input  logic                          read_out,
   output logic [$clog2(FIFO_DEPTH):0]   pkt_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          drop_pulse
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int IW = WORD_WIDTH + 2;
   localparam logic [PW-1:0] ONE_P = PW'(1);
   localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
   localparam logic [WORD_WIDTH-1:0] ONE_W = WORD_WIDTH'(1);
   localparam logic [IW-1:0] ONE_I = IW'(1);
   localparam logic [IW-1:0] TWO_I = IW'(2);

   typedef enum logic [2:0] {
      IN_DA, IN_SA, IN_LEN, IN_PAY, IN_DROP
   } in_st_e;

   typedef enum logic {
      IDLE, SEND
   } out_st_e;

   logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];

   in_st_e in_st_q, in_st_d;
   out_st_e out_st_q, out_st_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] pkt_q, pkt_d;
   logic [WORD_WIDTH-1:0] rem_q, rem_d;
   logic [WORD_WIDTH-1:0] olen_q, olen_d;
   logic [IW-1:0] idx_q, idx_d;
   logic drop_q, drop_d;
   logic alive_q;

   logic [PW-1:0] level_w;
   logic [WORD_WIDTH-1:0] rd_data_w;
   logic full_w, acc_w, oversize_w;
   logic we_w, commit_w, eop_w;

   assign level_w = wr_ptr_q - rd_ptr_q;
   assign full_w = (level_w == DEPTH_P);
   assign rd_data_w = mem_q[rd_ptr_q[AW-1:0]];
   assign oversize_w = (32'(in_data) + 32'd3) > 32'(FIFO_DEPTH);
   assign acc_w = in_valid && in_ready;

   assign fifo_level = level_w;
   assign pkt_count = pkt_q;
   assign drop_pulse = drop_q;
   assign sw_enable_in = (out_st_q == SEND);
   assign data_in = (out_st_q == SEND) ? rd_data_w : '0;

   // Host side can push while not full; discarded bytes always flow.
   always_comb begin
      in_ready = 1'b0;
      if (alive_q)
         in_ready = (in_st_q == IN_DROP) || !full_w;
   end

   // Input FSM: speculative writes, commit on last byte, rollback on oversize.
   always_comb begin
      in_st_d = in_st_q;
      wr_ptr_d = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rem_d = rem_q;
      drop_d = 1'b0;
      we_w = 1'b0;
      commit_w = 1'b0;
      if (acc_w) begin
         unique case (in_st_q)
            IN_DA: begin
               we_w = 1'b1;
               in_st_d = IN_SA;
            end
            IN_SA: begin
               we_w = 1'b1;
               in_st_d = IN_LEN;
            end
            IN_LEN: begin
               rem_d = in_data;
               if (oversize_w) begin
                  wr_ptr_d = commit_ptr_q;
                  drop_d = 1'b1;
                  in_st_d = (in_data == '0) ? IN_DA : IN_DROP;
               end else begin
                  we_w = 1'b1;
                  if (in_data == '0)
                     commit_w = 1'b1;
                  else
                     in_st_d = IN_PAY;
               end
            end
            IN_PAY: begin
               we_w = 1'b1;
               rem_d = rem_q - ONE_W;
               if (rem_q == ONE_W)
                  commit_w = 1'b1;
            end
            IN_DROP: begin
               rem_d = rem_q - ONE_W;
               if (rem_q == ONE_W)
                  in_st_d = IN_DA;
            end
            default: in_st_d = IN_DA;
         endcase
      end
      if (we_w)
         wr_ptr_d = wr_ptr_q + ONE_P;
      if (commit_w) begin
         commit_ptr_d = wr_ptr_d;
         in_st_d = IN_DA;
      end
   end

   // Output FSM: stream one committed packet, pop on read_out.
   always_comb begin
      out_st_d = out_st_q;
      rd_ptr_d = rd_ptr_q;
      idx_d = idx_q;
      olen_d = olen_q;
      eop_w = 1'b0;
      unique case (out_st_q)
         IDLE: begin
            idx_d = '0;
            if (pkt_q != '0)
               out_st_d = SEND;
         end
         SEND: begin
            if (read_out) begin
               rd_ptr_d = rd_ptr_q + ONE_P;
               idx_d = idx_q + ONE_I;
               if (idx_q == TWO_I)
                  olen_d = rd_data_w;
               if (idx_q == TWO_I)
                  eop_w = (rd_data_w == '0);
               else
                  eop_w = (idx_q == IW'(olen_q) + TWO_I);
               if (eop_w) begin
                  out_st_d = IDLE;
                  idx_d = '0;
               end
            end
         end
         default: out_st_d = IDLE;
      endcase
   end

   // Committed-packet count; commit and end-of-packet cancel out.
   always_comb begin
      pkt_d = pkt_q;
      if (commit_w && !eop_w)
         pkt_d = pkt_q + ONE_P;
      else if (eop_w && !commit_w)
         pkt_d = pkt_q - ONE_P;
   end

   // Buffer storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (we_w)
         mem_q[wr_ptr_q[AW-1:0]] <= in_data;
   end

   // State and pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_st_q <= IN_DA;
         out_st_q <= IDLE;
         wr_ptr_q <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q <= '0;
         pkt_q <= '0;
         rem_q <= '0;
         olen_q <= '0;
         idx_q <= '0;
         drop_q <= 1'b0;
         alive_q <= 1'b0;
      end else begin
         in_st_q <= in_st_d;
         out_st_q <= out_st_d;
         wr_ptr_q <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pkt_q <= pkt_d;
         rem_q <= rem_d;
         olen_q <= olen_d;
         idx_q <= idx_d;
         drop_q <= drop_d;
         alive_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_switch_pkt_feeder.sv
// Bench for switch_pkt_feeder: scoreboard on output bytes,
// table of packets plus directed corner sequences.
module tb_switch_pkt_feeder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic in_ready;
   logic sw_enable_in;
   logic [7:0] data_in;
   logic read_out = 1'b0;
   logic [6:0] pkt_count;
   logic [6:0] fifo_level;
   logic drop_pulse;

   switch_pkt_feeder #(.WORD_WIDTH(8), .FIFO_DEPTH(64)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .sw_enable_in(sw_enable_in),
      .data_in(data_in),
      .read_out(read_out),
      .pkt_count(pkt_count),
      .fifo_level(fifo_level),
      .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] da;
      logic [7:0] sa;
      logic [7:0] len;
      int exp_drops;
      int exp_blen;
   } vec_t;

   vec_t vt[6];
   int n_pass = 0;
   int n_tot = 0;
   logic [7:0] exp_q[$];
   int blen_q[$];
   int drop_cnt = 0;
   bit mon_en = 1'b0;
   bit en_prev = 1'b0;
   int cur_len = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int blen_at(input int i);
      if (i < blen_q.size())
         return blen_q[i];
      return -1;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit push);
      int n = 0;
      in_valid = 1'b1;
      in_data = b;
      while (!in_ready && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000)
         chk("in_ready_timeout", 0, 1);
      if (push)
         exp_q.push_back(b);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] da, input logic [7:0] sa,
                           input logic [7:0] len, input bit push);
      send_byte(da, push);
      send_byte(sa, push);
      send_byte(len, push);
      for (int k = 0; k < int'(len); k++)
         send_byte(8'($urandom_range(0, 255)), push);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || pkt_count != 0 || sw_enable_in)
             && n < 3000) begin
         tick();
         n++;
      end
      chk("drain_done", int'(n < 3000), 1);
      tick();
      chk("sb_empty", exp_q.size(), 0);
   endtask

   // Output monitor: burst lengths, drop pulses, scoreboard compare.
   always @(negedge clk) begin
      if (sw_enable_in)
         cur_len++;
      else if (en_prev) begin
         blen_q.push_back(cur_len);
         cur_len = 0;
      end
      en_prev = sw_enable_in;
      if (mon_en) begin
         if (drop_pulse)
            drop_cnt++;
         if (sw_enable_in && read_out) begin
            if (exp_q.size() == 0)
               chk("extra_byte", int'(data_in), -1);
            else
               chk("data_in", int'(data_in), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int d0;
      vt[0] = '{8'h10, 8'h20, 8'd0, 0, 3};
      vt[1] = '{8'h11, 8'h21, 8'd5, 0, 8};
      vt[2] = '{8'h12, 8'h22, 8'd62, 1, 0};
      vt[3] = '{8'h13, 8'h23, 8'd60, 0, 63};
      vt[4] = '{8'h14, 8'h24, 8'd61, 0, 64};
      vt[5] = '{8'h15, 8'h25, 8'd255, 1, 0};

      rst = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_sw_en", int'(sw_enable_in), 0);
      chk("rst_data_in", int'(data_in), 0);
      chk("rst_pkt_count", int'(pkt_count), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_drop", int'(drop_pulse), 0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", int'(in_ready), 1);
      mon_en = 1'b1;

      read_out = 1'b1;
      blen_q.delete();
      send_pkt(8'h01, 8'h22, 8'd0, 1);
      wait_drain();
      blen_q.delete();
      send_byte(8'h01, 1);
      send_byte(8'h22, 1);
      send_byte(8'h02, 1);
      send_byte(8'hAA, 1);
      send_byte(8'hBB, 1);
      chk("single_pkt_count", int'(pkt_count), 1);
      chk("single_not_yet", int'(sw_enable_in), 0);
      tick();
      chk("single_sw_en", int'(sw_enable_in), 1);
      chk("single_first", int'(data_in), 8'h01);
      wait_drain();
      chk("single_bursts", blen_q.size(), 1);
      chk("single_blen", blen_at(0), 5);
      chk("single_pkt_zero", int'(pkt_count), 0);

      blen_q.delete();
      send_pkt(8'h30, 8'h31, 8'd0, 1);
      send_pkt(8'h40, 8'h41, 8'd1, 1);
      wait_drain();
      chk("b2b_bursts", blen_q.size(), 2);
      chk("b2b_blen0", blen_at(0), 3);
      chk("b2b_blen1", blen_at(1), 4);

      for (int i = 0; i < 6; i++) begin
         blen_q.delete();
         d0 = drop_cnt;
         send_pkt(vt[i].da, vt[i].sa, vt[i].len, vt[i].exp_drops == 0);
         wait_drain();
         chk("tbl_drops", drop_cnt - d0, vt[i].exp_drops);
         chk("tbl_blen", blen_at(0),
             (vt[i].exp_blen > 0) ? vt[i].exp_blen : -1);
         chk("tbl_nbursts", blen_q.size(), int'(vt[i].exp_blen > 0));
         chk("tbl_level", int'(fifo_level), 0);
         chk("tbl_pkt_count", int'(pkt_count), 0);
      end

      read_out = 1'b0;
      blen_q.delete();
      for (int p = 0; p < 4; p++)
         send_pkt(8'h50 + 8'(p), 8'h60, 8'd13, 1);
      chk("full_level", int'(fifo_level), 64);
      chk("full_ready", int'(in_ready), 0);
      chk("full_pkts", int'(pkt_count), 4);
      chk("full_sw_en", int'(sw_enable_in), 1);
      chk("full_hold0", int'(data_in), 8'h50);
      tick();
      chk("full_hold1", int'(data_in), 8'h50);
      read_out = 1'b1;
      tick();
      chk("full_ready_back", int'(in_ready), 1);
      chk("full_level_pop", int'(fifo_level), 63);
      wait_drain();
      chk("full_bursts", blen_q.size(), 4);

      read_out = 1'b0;
      blen_q.delete();
      send_pkt(8'h70, 8'h71, 8'd1, 1);
      send_byte(8'h80, 1);
      send_byte(8'h81, 1);
      send_byte(8'h02, 1);
      send_byte(8'h82, 1);
      chk("coin_pre_pkts", int'(pkt_count), 1);
      chk("coin_pre_en", int'(sw_enable_in), 1);
      read_out = 1'b1;
      tick();
      tick();
      tick();
      send_byte(8'h83, 1);
      chk("coin_pkts", int'(pkt_count), 1);
      chk("coin_idle", int'(sw_enable_in), 0);
      wait_drain();
      chk("coin_bursts", blen_q.size(), 2);
      chk("coin_blen1", blen_at(1), 5);

      mon_en = 1'b0;
      read_out = 1'b0;
      send_pkt(8'h01, 8'h22, 8'd2, 0);
      tick();
      chk("rs_sw_en", int'(sw_enable_in), 1);
      read_out = 1'b1;
      tick();
      tick();
      chk("rs_mid_byte", int'(data_in), 2);
      rst = 1'b1;
      tick();
      chk("rs_sw_en_low", int'(sw_enable_in), 0);
      chk("rs_data", int'(data_in), 0);
      chk("rs_pkts", int'(pkt_count), 0);
      chk("rs_level", int'(fifo_level), 0);
      chk("rs_ready", int'(in_ready), 0);
      chk("rs_drop", int'(drop_pulse), 0);
      rst = 1'b0;
      tick();
      chk("rs_ready_back", int'(in_ready), 1);
      exp_q.delete();
      mon_en = 1'b1;
      blen_q.delete();
      send_pkt(8'h90, 8'h91, 8'd3, 1);
      wait_drain();
      chk("rs_next_blen", blen_at(0), 6);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/switch_pkt_feeder.md
# switch_pkt_feeder

Store-and-forward ingress stage that sits directly upstream of the switch input interface. It accepts packet bytes from a host-side valid/ready stream and buffers them in a FIFO. It commits only complete packets and drives the switch's `sw_enable_in`/`data_in` pair, popping one byte per cycle on `read_out`. Packets that could never fit in the buffer are discarded with rollback, so a partial packet never reaches the switch.

## Interface
- `WORD_WIDTH`, 8, byte width of host and switch data.
- `FIFO_DEPTH`, 64, buffer entries; power of 2, ≥ 4.
- `clk` input 1: single clock; all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: host byte valid.
- `in_data` input WORD_WIDTH: host byte.
- `in_ready` output 1: block accepts the byte this cycle.
- `sw_enable_in` output 1: packet framing to switch; high for the whole packet.
- `data_in` output WORD_WIDTH: current byte to switch.
- `read_out` input 1: switch consumed `data_in` this cycle.
- `pkt_count` output $clog2(FIFO_DEPTH)+1: committed packets not yet fully sent.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: entries between `rd_ptr` and uncommitted `wr_ptr`.
- `drop_pulse` output 1: one-cycle pulse when an oversize packet is discarded.

## Operation
- Packet format: DA, SA, LEN, then LEN payload bytes. Total length is LEN+3; LEN=0 is legal.
- Pointers: `rd_ptr`, `wr_ptr` (speculative), `commit_ptr` (end of last complete packet). Each is $clog2(FIFO_DEPTH)+1 bits with wrap bit.
- Input FSM states:
  - IN_DA → IN_SA → IN_LEN → IN_PAY → IN_DA.
  - IN_DROP is a separate state.
  - An accepted byte is one with `in_valid && in_ready`.
- IN_LEN, on accept:
  - If LEN+3 > FIFO_DEPTH, do not write the byte. Set `wr_ptr` ← `commit_ptr`, pulse `drop_pulse`, load the remaining count with LEN and go to IN_DROP. If LEN=0, go straight to IN_DA.
  - Otherwise, write the byte and load the remaining count with LEN. If LEN=0, commit immediately.
- IN_PAY: write each byte and decrement the count; the final byte commits.
- Commit: `commit_ptr` ← `wr_ptr` after the write, `pkt_count` +1, FSM → IN_DA.
- IN_DROP: `in_ready`=1; accept and discard LEN bytes, then → IN_DA.
- `in_ready` in write states is high when the FIFO is not full (`wr_ptr` − `rd_ptr` < FIFO_DEPTH), and low otherwise.
- An in-range packet larger than the current free space stalls on `in_ready`=0. It never deadlocks, because the output side drains committed data.
- Output FSM states:
  - IDLE: `sw_enable_in`=0, `data_in`=0. When `pkt_count`>0, go to SEND.
  - SEND: `sw_enable_in`=1, `data_in`=mem[`rd_ptr`].
- SEND byte handling:
  - Each cycle with `read_out`=1 pops one byte: `rd_ptr`+1, index+1.
  - When index 2 is popped, capture LEN.
  - Popping byte LEN+2 is the end of packet: → IDLE, `pkt_count` −1.
- `read_out` is ignored while `sw_enable_in`=0. The output side never reads past `commit_ptr`.
- Commit and end-of-packet in the same cycle: `pkt_count` stays unchanged. Both pointers still update.
- Write and pop in the same cycle are both legal; `fifo_level` reflects both.

## Timing
- Reset (`rst`=1 at an edge) has these values after that edge:
  - `in_ready`=0, `sw_enable_in`=0, `data_in`=0, `pkt_count`=0, `fifo_level`=0, `drop_pulse`=0.
  - All pointers are 0; both FSMs are at IN_DA/IDLE.
  - `in_ready` rises the first cycle after `rst` deasserts.
- Reset mid-packet on either side discards all buffer contents. `sw_enable_in` falls at the reset edge, with no flush.
- Input-to-output latency:
  - The last byte is accepted at edge T, and `pkt_count` updates after T.
  - `sw_enable_in`=1 after edge T+1, giving a minimum 2-cycle cut-through delay.
- The output registers `sw_enable_in`. After the final pop the signal is 0 for at least one cycle before the next packet, so the switch sees a deasserted gap between packets.
- `data_in` is stable while `sw_enable_in`=1 and `read_out`=0; it advances on the cycle after a pop.
- `drop_pulse` is high exactly one cycle: the cycle after the oversize LEN byte is accepted.

## Test plan
- Single packet: DA=0x01, SA=0x22, LEN=2, payload 0xAA 0xBB, with `read_out` held 1.
  - `pkt_count`=1, then `sw_enable_in` high for exactly 5 cycles.
  - `data_in` sequence: 01,22,02,AA,BB; then `pkt_count`=0.
- LEN=0 packet, followed back-to-back by a LEN=1 packet.
  - Two framed bursts of 3 and 4 bytes, with ≥1 idle cycle between them.
- Oversize packet: DA,SA,LEN=62 with FIFO_DEPTH=64, followed by 62 payload bytes.
  - `drop_pulse` fires once, `fifo_level` returns to its pre-packet value and `pkt_count` stays 0.
  - A following valid packet is sent intact.
- Full FIFO: `read_out` held 0 while 64 bytes of committed packets are written.
  - `in_ready`=0 at level 64.
  - Releasing `read_out` re-raises `in_ready` the cycle after the first pop.
- Simultaneous commit and end-of-packet: `pkt_count` holds its value across the event; no byte is lost or duplicated.
- Reset asserted mid-SEND, after 2 of 5 bytes: all outputs take reset values after that edge, and the next packet is sent from its DA byte.
